// File: rtl/lcd_frame_capture.sv
// SM510 LCD common/segment demux into a double-buffered 4x32 bitmap.
// Define LCD_GHOST_EN to OR the previous frame into reads (LCD persistence).
module lcd_frame_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLANK_TIMEOUT = 1048576,
    parameter int TO_W          = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] segA,
    input  logic [15:0] segB,
    input  logic [3:0]  H,
    input  logic [6:0]  rd_addr,
    output logic        rd_data,
    output logic        frame_strobe,
    output logic        frame_valid,
    output logic        blank
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BLANK_TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t          state;
    logic [3:0]      H_q;
    logic [31:0]     seg_q;
    logic [3:0]      last_h;
    logic [3:0]      h_cap;
    logic [3:0]      seen;
    logic [SW-1:0]   settle_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [127:0]    work;
    logic [127:0]    disp;

    logic       h_ok;
    logic [1:0] row;
    logic       capture;
    logic       full;
    logic       swap;
    logic       to_hit;
    logic       rd_bit;

    function automatic logic [1:0] idx(input logic [3:0] h);
        logic [1:0] r;
        r = 2'd3;
        unique case (1'b1)
            h[0]:    r = 2'd0;
            h[1]:    r = 2'd1;
            h[2]:    r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    always_comb begin
        h_ok    = (H_q != 4'd0) && ((H_q & (H_q - 4'd1)) == 4'd0);
        row     = idx(h_cap);
        capture = (state == CAPTURE);
        full    = ((seen | 4'b1000) == 4'hF);
        swap    = capture && (row == 2'd3) && full;
        to_hit  = !capture && (to_cnt == TO_MAX - TO_W'(1));
    end

`ifdef LCD_GHOST_EN
    logic [127:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (to_hit) begin
            prev <= '0;
        end else if (swap) begin
            prev <= disp;
        end
    end

    assign rd_bit = disp[rd_addr] | prev[rd_addr];
`else
    assign rd_bit = disp[rd_addr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            H_q          <= '0;
            seg_q        <= '0;
            last_h       <= '0;
            h_cap        <= '0;
            seen         <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            work         <= '0;
            disp         <= '0;
            rd_data      <= 1'b0;
            frame_strobe <= 1'b0;
            frame_valid  <= 1'b0;
            blank        <= 1'b1;
        end else begin
            H_q          <= H;
            seg_q        <= {segB, segA};
            rd_data      <= rd_bit;
            frame_strobe <= 1'b0;

            if (capture)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + TO_W'(1);

            unique case (state)
                IDLE: begin
                    if (h_ok && H_q != last_h) begin
                        state      <= SETTLE;
                        h_cap      <= H_q;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    // a common change mid-settle restarts phase detection
                    if (H_q != h_cap)
                        state <= IDLE;
                    else if (settle_cnt == '0)
                        state <= CAPTURE;
                    else
                        settle_cnt <= settle_cnt - SW'(1);
                end
                CAPTURE: begin
                    state                   <= IDLE;
                    work[{row, 5'd0} +: 32] <= seg_q;
                    last_h                  <= h_cap;
                    if (row == 2'd3)
                        seen <= '0;
                    else
                        seen <= seen | h_cap;
                    if (swap) begin
                        disp         <= {seg_q, work[95:0]};
                        frame_strobe <= 1'b1;
                        frame_valid  <= 1'b1;
                        blank        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (to_hit) begin
                blank       <= 1'b1;
                frame_valid <= 1'b0;
                disp        <= '0;
                work        <= '0;
                seen        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture with a short blank timeout.
// Build with LCD_GHOST_EN defined to exercise persistence reads.
module tb_lcd_frame_capture;
    localparam int BT = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] segA;
    logic [15:0] segB;
    logic [3:0]  H;
    logic [6:0]  rd_addr;
    logic        rd_data;
    logic        frame_strobe;
    logic        frame_valid;
    logic        blank;

    int passed = 0;
    int total  = 0;
    int strobes = 0;

    lcd_frame_capture #(
        .SETTLE_CYCLES(4),
        .BLANK_TIMEOUT(BT),
        .TO_W(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .segA(segA),
        .segB(segB),
        .H(H),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_strobe(frame_strobe),
        .frame_valid(frame_valid),
        .blank(blank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_strobe === 1'b1) strobes++;

    task automatic phase(input logic [3:0] h, input logic [31:0] d, input int n);
        H = h;
        {segB, segA} = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
        phase(4'b0001, r0, 20);
        phase(4'b0010, r1, 20);
        phase(4'b0100, r2, 20);
        phase(4'b1000, r3, 20);
    endtask

    task automatic rd(input logic [6:0] a, output logic v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        H = 4'd0;
        segA = '0;
        segB = '0;
        rd_addr = '0;
        #23;
        @(negedge clk);
        total++;
        if (blank !== 1'b1) $display("FAIL rst_blank got %b want 1", blank);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_data !== 1'b0) $display("FAIL rst_rd got %b want 0", rd_data);
        else passed++;
        total++;
        if (frame_valid !== 1'b0) $display("FAIL rst_fv got %b want 0", frame_valid);
        else passed++;
        repeat (BT + 20) @(posedge clk);
        @(negedge clk);
        total++;
        if (blank !== 1'b1) $display("FAIL idle_blank got %b want 1", blank);
        else passed++;
        total++;
        if (strobes !== 0) $display("FAIL idle_strobe got %0d want 0", strobes);
        else passed++;
        total++;
        if (frame_valid !== 1'b0) $display("FAIL idle_fv got %b want 0", frame_valid);
        else passed++;
    endtask

    task automatic test_frame();
        int s0;
        logic v;
        logic [6:0] addrs [6] = '{7'h00, 7'h3F, 7'h48, 7'h7F, 7'h01, 7'h47};
        logic       exps  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s0 = strobes;
        phase(4'b0001, 32'h0000_0001, 20);
        phase(4'b0010, 32'h8000_0000, 20);
        phase(4'b0100, 32'h00FF_FF00, 20);
        total++;
        if (strobes !== s0) $display("FAIL frame_early_strobe got %0d want %0d", strobes, s0);
        else passed++;
        phase(4'b1000, 32'hFFFF_FFFF, 20);
        total++;
        if (strobes !== s0 + 1) $display("FAIL frame_strobe got %0d want %0d", strobes, s0 + 1);
        else passed++;
        total++;
        if (frame_valid !== 1'b1) $display("FAIL frame_fv got %b want 1", frame_valid);
        else passed++;
        total++;
        if (blank !== 1'b0) $display("FAIL frame_blank got %b want 0", blank);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], v);
            total++;
            if (v !== exps[i]) $display("FAIL frame_rd addr %h got %b want %b", addrs[i], v, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        int s0;
        logic v;
        logic [6:0] addrs [4] = '{7'h28, 7'h24, 7'h10, 7'h04};
        logic       exps  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        s0 = strobes;
        phase(4'b0001, 32'h0000_00F0, 2);
        phase(4'b0010, 32'h0000_0F00, 20);
        phase(4'b0100, 32'h0, 20);
        phase(4'b1000, 32'h0, 20);
        total++;
        if (strobes !== s0) $display("FAIL glitch_row0 got %0d want %0d", strobes, s0);
        else passed++;
        phase(4'b0001, 32'h0000_00F0, 2);
        phase(4'b0010, 32'h0000_0F00, 20);
        phase(4'b0001, 32'h0001_0000, 20);
        phase(4'b0100, 32'h0, 20);
        phase(4'b1000, 32'h0, 20);
        total++;
        if (strobes !== s0 + 1) $display("FAIL glitch_swap got %0d want %0d", strobes, s0 + 1);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], v);
            total++;
            if (v !== exps[i]) $display("FAIL glitch_rd addr %h got %b want %b", addrs[i], v, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_invalid();
        int s0;
        logic v;
        s0 = strobes;
        phase(4'b0000, 32'hFFFF_FFFF, 150);
        phase(4'b0110, 32'hFFFF_FFFF, 100);
        total++;
        if (blank !== 1'b0) $display("FAIL inv_blank_early got %b want 0", blank);
        else passed++;
        total++;
        if (strobes !== s0) $display("FAIL inv_strobe got %0d want %0d", strobes, s0);
        else passed++;
        phase(4'b0110, 32'hFFFF_FFFF, 50);
        total++;
        if (blank !== 1'b1) $display("FAIL inv_blank got %b want 1", blank);
        else passed++;
        total++;
        if (frame_valid !== 1'b0) $display("FAIL inv_fv got %b want 0", frame_valid);
        else passed++;
        rd(7'h10, v);
        total++;
        if (v !== 1'b0) $display("FAIL inv_rd got %b want 0", v);
        else passed++;
    endtask

    task automatic test_skip();
        int s0;
        logic v;
        logic [6:0] addrs [6] = '{7'h00, 7'h01, 7'h22, 7'h43, 7'h64, 7'h60};
        logic       exps  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s0 = strobes;
        phase(4'b0001, 32'h5555_5555, 20);
        phase(4'b0010, 32'h5555_5555, 20);
        phase(4'b1000, 32'h5555_5555, 20);
        total++;
        if (strobes !== s0) $display("FAIL skip_nostrobe got %0d want %0d", strobes, s0);
        else passed++;
        total++;
        if (blank !== 1'b1) $display("FAIL skip_blank1 got %b want 1", blank);
        else passed++;
        frame(32'h2, 32'h4, 32'h8, 32'h10);
        total++;
        if (strobes !== s0 + 1) $display("FAIL skip_strobe got %0d want %0d", strobes, s0 + 1);
        else passed++;
        total++;
        if (blank !== 1'b0) $display("FAIL skip_blank0 got %b want 0", blank);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], v);
            total++;
            if (v !== exps[i]) $display("FAIL skip_rd addr %h got %b want %b", addrs[i], v, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_persist();
        logic v;
        logic ghost;
`ifdef LCD_GHOST_EN
        ghost = 1'b1;
`else
        ghost = 1'b0;
`endif
        frame(32'h20, 32'h0, 32'h0, 32'h0);
        rd(7'h05, v);
        total++;
        if (v !== 1'b1) $display("FAIL persist_lit got %b want 1", v);
        else passed++;
        frame(32'h0, 32'h0, 32'h0, 32'h0);
        rd(7'h05, v);
        total++;
        if (v !== ghost) $display("FAIL persist_ghost got %b want %b", v, ghost);
        else passed++;
        frame(32'h0, 32'h0, 32'h0, 32'h0);
        rd(7'h05, v);
        total++;
        if (v !== 1'b0) $display("FAIL persist_gone got %b want 0", v);
        else passed++;
    endtask

    task automatic test_freeze();
        int s0;
        logic v;
        logic [6:0] addrs [4] = '{7'h00, 7'h3F, 7'h5A, 7'h7F};
        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (blank !== 1'b0) $display("FAIL freeze_pre_blank got %b want 0", blank);
        else passed++;
        rd(7'h33, v);
        total++;
        if (v !== 1'b1) $display("FAIL freeze_pre_rd got %b want 1", v);
        else passed++;
        s0 = strobes;
        phase(4'b1000, 32'hFFFF_FFFF, BT + 20);
        total++;
        if (blank !== 1'b1) $display("FAIL freeze_blank got %b want 1", blank);
        else passed++;
        total++;
        if (frame_valid !== 1'b0) $display("FAIL freeze_fv got %b want 0", frame_valid);
        else passed++;
        total++;
        if (strobes !== s0) $display("FAIL freeze_strobe got %0d want %0d", strobes, s0);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], v);
            total++;
            if (v !== 1'b0) $display("FAIL freeze_rd addr %h got %b want 0", addrs[i], v);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_invalid();
        test_skip();
        test_persist();
        test_freeze();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
